// File: rtl/f2h_sdram_sim_pkg.sv
// -----------------------------------------------------------------------------
// f2h_sdram_sim_pkg
//   Shared types and constants for the simulation-only f2h_sdram responder.
//   - rd_state_t / wr_state_t : read and write FSM encodings
//   - BURST_CNT_W             : beat counter width (holds 256 without overflow)
//   - eff_count()             : maps an Avalon burstcount to the beat count served
// -----------------------------------------------------------------------------
package f2h_sdram_sim_pkg;

    localparam int BURST_CNT_W = 9;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_LAT   = 2'd1,
        RD_BURST = 2'd2
    } rd_state_t;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_BURST = 1'b1
    } wr_state_t;

    // A burstcount of 0 is illegal on Avalon; it is served as a single beat
    // (the caller flags the error separately).
    function automatic logic [BURST_CNT_W-1:0] eff_count(input logic [7:0] burstcount);
        return (burstcount == 8'd0) ? BURST_CNT_W'(1) : BURST_CNT_W'(burstcount);
    endfunction

endpackage

// File: rtl/f2h_sdram_responder_if.sv
// -----------------------------------------------------------------------------
// f2h_sdram_responder_if
//   Bundles the read-only and write-only Avalon-MM burst ports of the
//   FPGA-to-HPS SDRAM bridge plus the responder's sticky error flag.
//   master : the frame-buffer reader/writer side (drives requests)
//   slave  : the responder side (drives waitrequest, read data, error)
// -----------------------------------------------------------------------------
interface f2h_sdram_responder_if #(
    parameter int ADDR_WIDTH = 29,
    parameter int DATA_WIDTH = 64
);

    // read port
    logic [ADDR_WIDTH-1:0]   rd_address;
    logic [7:0]              rd_burstcount;
    logic                    rd_read;
    logic                    rd_waitrequest;
    logic [DATA_WIDTH-1:0]   rd_readdata;
    logic                    rd_readdatavalid;

    // write port
    logic [ADDR_WIDTH-1:0]   wr_address;
    logic [7:0]              wr_burstcount;
    logic                    wr_write;
    logic [DATA_WIDTH-1:0]   wr_writedata;
    logic [DATA_WIDTH/8-1:0] wr_byteenable;
    logic                    wr_waitrequest;

    // status
    logic                    burst_err;

    modport master (
        output rd_address, rd_burstcount, rd_read,
        input  rd_waitrequest, rd_readdata, rd_readdatavalid,
        output wr_address, wr_burstcount, wr_write, wr_writedata, wr_byteenable,
        input  wr_waitrequest,
        input  burst_err
    );

    modport slave (
        input  rd_address, rd_burstcount, rd_read,
        output rd_waitrequest, rd_readdata, rd_readdatavalid,
        input  wr_address, wr_burstcount, wr_write, wr_writedata, wr_byteenable,
        output wr_waitrequest,
        output burst_err
    );

endinterface

// File: rtl/f2h_sdram_sim_mem.sv
// -----------------------------------------------------------------------------
// f2h_sdram_sim_mem
//   1R/1W synchronous word array with per-byte write enable.
//   A read and write to the same word on the same edge returns the old data.
//   Ports:
//     clk, rst_n       clock, async active-low reset (read register only)
//     rd_en, rd_addr   read strobe / word index; rd_data updates on the edge
//     rd_data          registered read data, holds while rd_en=0
//     wr_en, wr_addr   write strobe / word index
//     wr_data, wr_be   write data and per-byte enables
// -----------------------------------------------------------------------------
module f2h_sdram_sim_mem #(
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_WORDS_LOG2 = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_en,
    input  logic [MEM_WORDS_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    input  logic                      wr_en,
    input  logic [MEM_WORDS_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**MEM_WORDS_LOG2];

    // NOTE: the array has no reset -- contents survive reset, which is what
    // the bench relies on, and a reset would block mapping onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking assignment here is what gives read-old-on-collision:
    // mem[] is sampled before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/f2h_sdram_responder.sv
// -----------------------------------------------------------------------------
// f2h_sdram_responder
//   Simulation-only responder for the FPGA-to-HPS SDRAM Avalon-MM burst ports.
//   Serves a read-only and a write-only burst port from an internal array with
//   a fixed read latency and optional periodic write back-pressure.
//   Ports:
//     clk_clk        sole clock
//     reset_reset_n  asynchronous active-low reset
//     bus            f2h_sdram_responder_if.slave (both ports + burst_err)
//   Parameters:
//     ADDR_WIDTH, DATA_WIDTH  bus geometry (must match the interface)
//     MEM_WORDS_LOG2          array depth = 2**MEM_WORDS_LOG2 words
//     READ_LATENCY            acceptance edge to first readdatavalid (>=1)
//     WR_STALL_PERIOD         0 = never stall, N = stall 1 cycle of every N
// -----------------------------------------------------------------------------
module f2h_sdram_responder
    import f2h_sdram_sim_pkg::*;
#(
    parameter int ADDR_WIDTH      = 29,
    parameter int DATA_WIDTH      = 64,
    parameter int MEM_WORDS_LOG2  = 12,
    parameter int READ_LATENCY    = 4,
    parameter int WR_STALL_PERIOD = 0
) (
    input logic                  clk_clk,
    input logic                  reset_reset_n,
    f2h_sdram_responder_if.slave bus
);

    localparam int MW = MEM_WORDS_LOG2;

    // RD_LAT lasts READ_LATENCY-1 cycles; the fetch cycle in RD_BURST makes
    // the last one, and the memory output register lands on the edge after.
    localparam logic [7:0]  LAT_END    = 8'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
    localparam logic [15:0] STALL_LAST = 16'(WR_STALL_PERIOD > 0 ? WR_STALL_PERIOD - 1 : 0);

    // ------------------------------------------------------------------ read
    rd_state_t              rd_state;
    logic                   rd_wait_q;
    logic                   rd_valid_q;
    logic [MW-1:0]          rd_base;
    logic [BURST_CNT_W-1:0] rd_len;
    logic [BURST_CNT_W-1:0] rd_beat;
    logic [7:0]             lat_cnt;
    logic                   rd_accept;
    logic                   rd_fetch;
    logic                   rd_last;
    logic [MW-1:0]          rd_idx;
    logic [DATA_WIDTH-1:0]  rd_data;

    assign rd_accept = (rd_state == RD_IDLE) && bus.rd_read && !rd_wait_q;
    assign rd_fetch  = (rd_state == RD_BURST);
    assign rd_last   = (rd_beat == rd_len - BURST_CNT_W'(1));
    // Index arithmetic is MW bits wide, so bursts wrap modulo the depth.
    assign rd_idx    = rd_base + MW'(rd_beat);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_state   <= RD_IDLE;
            rd_wait_q  <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_base    <= '0;
            rd_len     <= '0;
            rd_beat    <= '0;
            lat_cnt    <= '0;
        end else begin
            // Valid tracks the fetch one cycle later, in step with rd_data.
            rd_valid_q <= rd_fetch;
            case (rd_state)
                RD_IDLE: begin
                    // Stays high from acceptance through the last beat's
                    // valid cycle; drops on the first idle edge after it.
                    rd_wait_q <= rd_accept;
                    if (rd_accept) begin
                        rd_base  <= bus.rd_address[MW-1:0];
                        rd_len   <= eff_count(bus.rd_burstcount);
                        rd_beat  <= '0;
                        lat_cnt  <= '0;
                        rd_state <= (READ_LATENCY > 1) ? RD_LAT : RD_BURST;
                    end
                end
                RD_LAT: begin
                    lat_cnt <= lat_cnt + 8'd1;
                    if (lat_cnt == LAT_END) begin
                        rd_state <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    rd_beat <= rd_beat + BURST_CNT_W'(1);
                    if (rd_last) begin
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign bus.rd_waitrequest   = rd_wait_q;
    assign bus.rd_readdatavalid = rd_valid_q;
    assign bus.rd_readdata      = rd_data;

    // ----------------------------------------------------------------- write
    wr_state_t              wr_state;
    logic                   wr_ready_q;
    logic [15:0]            stall_cnt;
    logic [MW-1:0]          wr_base;
    logic [BURST_CNT_W-1:0] wr_len;
    logic [BURST_CNT_W-1:0] wr_beat;
    logic [BURST_CNT_W-1:0] wr_len_in;
    logic                   wr_stall;
    logic                   wr_accept;
    logic                   wr_first;
    logic [MW-1:0]          wr_idx;

    assign wr_len_in          = eff_count(bus.wr_burstcount);
    assign wr_stall           = (WR_STALL_PERIOD > 0) && (stall_cnt == STALL_LAST);
    // wr_ready_q keeps waitrequest high during reset and drops it one edge later.
    assign bus.wr_waitrequest = !wr_ready_q || wr_stall;
    assign wr_accept          = bus.wr_write && !bus.wr_waitrequest;
    assign wr_first           = (wr_state == WR_IDLE);
    // The first beat writes straight to the presented address.
    assign wr_idx             = wr_first ? bus.wr_address[MW-1:0] : wr_base + MW'(wr_beat);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_state   <= WR_IDLE;
            wr_ready_q <= 1'b0;
            stall_cnt  <= '0;
            wr_base    <= '0;
            wr_len     <= '0;
            wr_beat    <= '0;
        end else begin
            wr_ready_q <= 1'b1;
            // Free-running: the stall slot is independent of burst activity.
            if (WR_STALL_PERIOD > 0) begin
                stall_cnt <= wr_stall ? '0 : stall_cnt + 16'd1;
            end
            if (wr_accept) begin
                if (wr_first) begin
                    wr_base <= bus.wr_address[MW-1:0];
                    wr_len  <= wr_len_in;
                    wr_beat <= BURST_CNT_W'(1);
                    if (wr_len_in != BURST_CNT_W'(1)) begin
                        wr_state <= WR_BURST;
                    end
                end else begin
                    wr_beat <= wr_beat + BURST_CNT_W'(1);
                    if (wr_beat == wr_len - BURST_CNT_W'(1)) begin
                        wr_state <= WR_IDLE;
                    end
                end
            end
        end
    end

    // ----------------------------------------------------------------- error
    logic burst_err_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            burst_err_q <= 1'b0;
        end else if ((rd_accept && bus.rd_burstcount == 8'd0) ||
                     (wr_accept && wr_first && bus.wr_burstcount == 8'd0)) begin
            burst_err_q <= 1'b1;
        end
    end

    assign bus.burst_err = burst_err_q;

    // Upper address bits select nothing in the modelled array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.rd_address[ADDR_WIDTH-1:MW], bus.wr_address[ADDR_WIDTH-1:MW]};

    // ---------------------------------------------------------------- memory
    f2h_sdram_sim_mem #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MEM_WORDS_LOG2 (MW)
    ) u_mem (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .rd_en   (rd_fetch),
        .rd_addr (rd_idx),
        .rd_data (rd_data),
        .wr_en   (wr_accept),
        .wr_addr (wr_idx),
        .wr_data (bus.wr_writedata),
        .wr_be   (bus.wr_byteenable)
    );

endmodule
